// File: rtl/nexus_micro_dequeue.sv
// Egress engine for the micro sort-and-shift PIFO: pops eligible head entries
// into a 2-entry skid FIFO feeding a valid/ready stream, with discard-all flush.
module nexus_micro_dequeue #(
  parameter int PTW = 16,
  parameter int MTW = 32
) (
  input  logic               i_clk,
  input  logic               i_arst_n,
  input  logic               i_en,
  input  logic               i_gate_en,
  input  logic [PTW-1:0]     i_now,
  input  logic               i_flush,
  input  logic [MTW+PTW-1:0] i_sorter_data,
  input  logic               i_sorter_empty,
  input  logic               i_sorter_push,
  output logic               o_sorter_pop,
  output logic               o_valid,
  output logic [MTW+PTW-1:0] o_data,
  input  logic               i_ready,
  output logic               o_hol_stall,
  output logic               o_flush_done,
  output logic [31:0]        o_deq_cnt
);

  localparam int EW = MTW + PTW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Serial-number compare: rank is due once now has reached it, modulo wrap.
  function automatic logic is_eligible(input logic gate,
                                       input logic [PTW-1:0] now,
                                       input logic [PTW-1:0] rank);
    logic [PTW-1:0] diff;
    diff = now - rank;
    return !gate || !diff[PTW-1];
  endfunction

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [EW-1:0]   slot0_q, slot0_d;
  logic [EW-1:0]   slot1_q, slot1_d;
  logic            flush_done_q, flush_done_d;
  logic [31:0]     deq_cnt_q, deq_cnt_d;

  logic            head_elig;
  logic            fifo_rd;
  logic            fifo_wr;
  logic            has_space;
  logic            pop;

  assign head_elig = is_eligible(i_gate_en, i_now, i_sorter_data[PTW-1:0]);
  assign o_valid   = (state_q != ST_FLUSH) && (cnt_q != 2'd0);
  assign o_data    = o_valid ? slot0_q : '0;
  assign fifo_rd   = o_valid & i_ready;
  assign has_space = (cnt_q != 2'd2) || fifo_rd;

  // Pop is suppressed under reset and whenever the sorter is taking a push.
  always_comb begin
    pop = 1'b0;
    if (i_arst_n && !i_sorter_empty && !i_sorter_push) begin
      case (state_q)
        ST_RUN:   pop = head_elig && has_space;
        ST_FLUSH: pop = 1'b1;
        default:  pop = 1'b0;
      endcase
    end
  end

  assign fifo_wr      = pop && (state_q == ST_RUN);
  assign o_sorter_pop = pop;
  assign o_hol_stall  = (state_q == ST_RUN) && !i_sorter_empty && !head_elig;
  assign o_flush_done = flush_done_q;
  assign o_deq_cnt    = deq_cnt_q;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({fifo_wr, fifo_rd})
      2'b10: begin
        if (cnt_q == 2'd0) slot0_d = i_sorter_data;
        else               slot1_d = i_sorter_data;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          slot0_d = i_sorter_data;
        end else begin
          slot0_d = slot1_q;
          slot1_d = i_sorter_data;
        end
      end
      default: ;
    endcase
    if (i_flush) cnt_d = 2'd0;
  end

  always_comb begin
    state_d      = state_q;
    flush_done_d = 1'b0;
    deq_cnt_d    = deq_cnt_q + (fifo_rd ? 32'd1 : 32'd0);
    if (i_flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_IDLE: if (i_en)  state_d = ST_RUN;
        ST_RUN:  if (!i_en) state_d = ST_IDLE;
        ST_FLUSH: begin
          if (i_sorter_empty) begin
            flush_done_d = 1'b1;
            state_d      = i_en ? ST_RUN : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_arst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      flush_done_q <= 1'b0;
      deq_cnt_q    <= 32'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_done_q <= flush_done_d;
      deq_cnt_q    <= deq_cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    slot0_q <= slot0_d;
    slot1_q <= slot1_d;
  end

endmodule

// File: tb/tb_nexus_micro_dequeue.sv
// Randomized bench for nexus_micro_dequeue: a queue-based sorter and output
// reference model predict pop, stream and status behaviour every cycle.
module tb_nexus_micro_dequeue;

  localparam int PTW = 16;
  localparam int MTW = 32;
  localparam int EW  = MTW + PTW;

  logic           clk = 1'b0;
  logic           arst_n = 1'b0;
  logic           en = 1'b0;
  logic           gate_en = 1'b0;
  logic [PTW-1:0] now = '0;
  logic           flush = 1'b0;
  logic [EW-1:0]  sorter_data = '0;
  logic           sorter_empty = 1'b1;
  logic           sorter_push = 1'b0;
  logic           sorter_pop;
  logic           valid;
  logic [EW-1:0]  data;
  logic           ready = 1'b0;
  logic           hol;
  logic           fdone;
  logic [31:0]    deq_cnt;

  always #5 clk = ~clk;

  nexus_micro_dequeue #(.PTW(PTW), .MTW(MTW)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_en(en), .i_gate_en(gate_en), .i_now(now),
    .i_flush(flush), .i_sorter_data(sorter_data), .i_sorter_empty(sorter_empty),
    .i_sorter_push(sorter_push), .o_sorter_pop(sorter_pop), .o_valid(valid),
    .o_data(data), .i_ready(ready), .o_hol_stall(hol), .o_flush_done(fdone),
    .o_deq_cnt(deq_cnt)
  );

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] srt[$];
  logic [EW-1:0] fq[$];
  int  mode = 0;
  int  exp_cnt = 0;
  bit  exp_fd = 1'b0;
  bit  chk_on = 1'b0;
  int  flush_pops = 0;
  int  fd_seen = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit elig_f(input bit g, input logic [15:0] nw, input logic [15:0] rk);
    int d;
    d = (int'(nw) - int'(rk) + 65536) % 65536;
    return !g || (d < 32768);
  endfunction

  task automatic sorter_insert(input logic [EW-1:0] e);
    int i;
    i = 0;
    while (i < srt.size() && srt[i][15:0] <= e[15:0]) i++;
    srt.insert(i, e);
  endtask

  task automatic step(input bit r, input bit e, input bit g, input bit f, input bit p,
                      input bit rdy, input logic [15:0] nw, input logic [EW-1:0] pd);
    bit empty, el, ev, hs, sp, ep, eh;
    logic [EW-1:0] hd, ed;
    @(negedge clk);
    arst_n = r; en = e; gate_en = g; flush = f; sorter_push = p; ready = rdy; now = nw;
    empty = (srt.size() == 0);
    hd = empty ? '0 : srt[0];
    sorter_empty = empty;
    sorter_data  = hd;
    el = elig_f(g, nw, hd[15:0]);
    ev = (mode != 2) && (fq.size() > 0);
    ed = ev ? fq[0] : '0;
    hs = ev && rdy;
    sp = (fq.size() < 2) || (fq.size() == 2 && hs);
    ep = r && !empty && !p && ((mode == 1 && el && sp) || mode == 2);
    eh = (mode == 1) && !empty && !el;
    #1;
    if (chk_on) begin
      check("pop", sorter_pop, ep);
      check("valid", valid, ev);
      check("data", data, ed);
      check("hol_stall", hol, eh);
      check("flush_done", fdone, exp_fd);
      check("deq_cnt", deq_cnt, exp_cnt);
    end
    if (mode == 2 && sorter_pop) flush_pops++;
    if (fdone) fd_seen++;
    @(posedge clk);
    if (!r) begin
      mode = 0; fq.delete(); exp_cnt = 0; exp_fd = 1'b0;
      if (p) sorter_insert(pd);
      chk_on = 1'b1;
    end else begin
      exp_fd = 1'b0;
      if (hs) begin void'(fq.pop_front()); exp_cnt++; end
      if (ep && mode == 1) fq.push_back(hd);
      if (p) sorter_insert(pd);
      else if (ep) void'(srt.pop_front());
      if (f) begin
        mode = 2; fq.delete();
      end else if (mode == 0) begin
        if (e) mode = 1;
      end else if (mode == 1) begin
        if (!e) mode = 0;
      end else if (empty) begin
        exp_fd = 1'b1; mode = e ? 1 : 0;
      end
    end
  endtask

  function automatic logic [EW-1:0] mk(input logic [15:0] rk);
    logic [31:0] meta;
    meta = $urandom;
    return {meta, rk};
  endfunction

  initial begin
    logic [15:0] nw;
    logic [15:0] rk;
    logic [31:0] cnt_before;
    int pct_push, pct_rdy, pct_gate;
    bit r, e, g, f, p, rdy;

    step(0, 0, 0, 0, 0, 0, 16'h0, '0);
    step(0, 0, 0, 0, 0, 0, 16'h0, '0);

    // Ungated drain of ranks 5,3,9
    step(1, 0, 0, 0, 1, 1, 16'h0, mk(16'd5));
    step(1, 0, 0, 0, 1, 1, 16'h0, mk(16'd3));
    step(1, 0, 0, 0, 1, 1, 16'h0, mk(16'd9));
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0, 0, 1, 16'h0, '0);
    check("drain_cnt", deq_cnt, 32'd3);

    // Gating and wrap
    step(1, 1, 1, 0, 1, 1, 16'd90, mk(16'd100));
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 16'd90, '0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 16'd100, '0);
    step(1, 1, 1, 0, 1, 1, 16'hFFF0, mk(16'h0002));
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 16'hFFF0, '0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 0, 0, 1, 16'h0003, '0);
    check("gate_cnt", deq_cnt, 32'd5);

    // Backpressure then flush: 8 queued, 2 land in the FIFO, 6 flushed
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 1, 0, 16'h0, mk(16'($urandom_range(0, 200))));
    for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0, 16'h0, '0);
    check("bp_fifo_valid", valid, 1'b1);
    cnt_before = deq_cnt;
    flush_pops = 0;
    fd_seen = 0;
    step(1, 0, 0, 1, 0, 0, 16'h0, '0);
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0, 1, 16'h0, '0);
    check("flush_pops", flush_pops, 6);
    check("flush_done_pulses", fd_seen, 1);
    check("flush_deq_cnt", deq_cnt, cnt_before);

    // Randomized phases
    nw = 16'hFF80;
    for (int i = 0; i < 3000; i++) begin
      case (i / 500)
        0: begin pct_push = 60; pct_rdy = 100; pct_gate = 0;  end
        1: begin pct_push = 50; pct_rdy = 70;  pct_gate = 100; end
        2: begin pct_push = 70; pct_rdy = 30;  pct_gate = 50; end
        3: begin pct_push = 40; pct_rdy = 90;  pct_gate = 100; end
        default: begin pct_push = 55; pct_rdy = 60; pct_gate = 50; end
      endcase
      nw = nw + 16'($urandom_range(0, 3));
      rk = nw + 16'($urandom_range(0, 60)) - 16'd30;
      r   = (i != 1700);
      e   = ($urandom_range(0, 99) < 90);
      g   = ($urandom_range(0, 99) < pct_gate);
      f   = ($urandom_range(0, 99) < 2);
      p   = ($urandom_range(0, 99) < pct_push) && (srt.size() < 10);
      rdy = ($urandom_range(0, 99) < pct_rdy);
      step(r, e, g, f, p, rdy, nw, mk(rk));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
